multichannel_moving_average: RTL and testbench

- Time-multiplexed, multi-channel successor of the single-channel moving average.
- Keeps an independent running sum of the last 2^window_log2 samples for each of NUM_CHANNELS interleaved channels.
- Outputs per-sample the full-precision sum, the truncated mean, the channel tag and a window-filled flag.
- Sits between the ADC sample demultiplexer and the per-channel detection logic.

---
 rtl/multichannel_moving_average.sv | 166 ++++++++++++++++
 tb/tb_multichannel_moving_average.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multichannel_moving_average.sv
// Time-multiplexed moving average over NUM_CHANNELS interleaved channels.
// Each channel keeps its own circular sample buffer, write pointer, fill
// count and running sum. A result emerges exactly two cycles after its
// enable cycle, with full throughput even for back-to-back samples on
// one channel.
module multichannel_moving_average #(
  parameter int DATA_SIZE       = 16,
  parameter int NUM_CHANNELS    = 4,
  parameter int MAX_WINDOW_LOG2 = 6,
  parameter int CH_W            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int WL_W            = $clog2(MAX_WINDOW_LOG2 + 1),
  parameter int FULL_SIZE       = DATA_SIZE + MAX_WINDOW_LOG2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] input_data,
  input  logic                        enable,
  input  logic [CH_W-1:0]             channel,
  input  logic [WL_W-1:0]             window_log2,
  input  logic                        flush,
  output logic signed [FULL_SIZE-1:0] output_data,
  output logic signed [DATA_SIZE-1:0] output_mean,
  output logic [CH_W-1:0]             output_channel,
  output logic                        output_data_valid,
  output logic                        output_window_full
);

  localparam int DEPTH = 1 << MAX_WINDOW_LOG2;
  localparam int CNT_W = MAX_WINDOW_LOG2 + 1;

  // Per-channel storage; the sample RAM is never cleared, the fill count
  // alone decides whether the value read back is a real oldest sample.
  logic signed [DATA_SIZE-1:0]       sample_mem [NUM_CHANNELS][DEPTH];
  logic [MAX_WINDOW_LOG2-1:0]        wr_ptr     [NUM_CHANNELS];
  logic [CNT_W-1:0]                  count      [NUM_CHANNELS];
  logic signed [FULL_SIZE-1:0]       sum_mem    [NUM_CHANNELS];

  logic [WL_W-1:0]            wl_clamped;
  logic [WL_W-1:0]            wl_reg;
  logic                       win_change;
  logic                       clear_all;
  logic                       accept;
  logic [CNT_W-1:0]           win_size;
  logic [MAX_WINDOW_LOG2-1:0] wr_idx;
  logic [MAX_WINDOW_LOG2-1:0] rd_idx;
  logic [CNT_W-1:0]           count_before;
  logic [CNT_W-1:0]           count_after;

  // Stage-1 registers carry everything stage 2 needs, including the
  // window of the sample, so in-flight results finish with old settings.
  logic                        s1_valid;
  logic [CH_W-1:0]             s1_ch;
  logic signed [DATA_SIZE-1:0] s1_data;
  logic signed [DATA_SIZE-1:0] s1_oldest;
  logic                        s1_drop;
  logic                        s1_full;
  logic [WL_W-1:0]             s1_wl;

  logic signed [FULL_SIZE-1:0] sample_ext;
  logic signed [FULL_SIZE-1:0] oldest_ext;
  logic signed [FULL_SIZE-1:0] sum_next;
  logic signed [FULL_SIZE-1:0] mean_full;

  // Stage-1 decode: clamp the window, detect clears, locate write/read slots.
  // A window change resets the channel state at this edge, so the incoming
  // sample is treated as landing in an empty buffer.
  always_comb begin
    wl_clamped   = (window_log2 > WL_W'(MAX_WINDOW_LOG2)) ? WL_W'(MAX_WINDOW_LOG2) : window_log2;
    win_change   = (wl_clamped != wl_reg);
    clear_all    = flush | win_change;
    accept       = enable && !flush && (int'(channel) < NUM_CHANNELS);
    win_size     = CNT_W'(1) << wl_clamped;
    wr_idx       = win_change ? '0 : wr_ptr[channel];
    count_before = win_change ? '0 : count[channel];
    rd_idx       = wr_idx - win_size[MAX_WINDOW_LOG2-1:0];
    count_after  = (count_before == CNT_W'(DEPTH)) ? count_before : count_before + 1'b1;
  end

  // Stage-2 arithmetic: the running sum of the channel was already written
  // back by the previous same-channel sample, so no extra forwarding needed.
  always_comb begin
    sample_ext = {{MAX_WINDOW_LOG2{s1_data[DATA_SIZE-1]}}, s1_data};
    oldest_ext = s1_drop ? {{MAX_WINDOW_LOG2{s1_oldest[DATA_SIZE-1]}}, s1_oldest} : '0;
    sum_next   = sum_mem[s1_ch] + sample_ext - oldest_ext;
    mean_full  = sum_next >>> s1_wl;
  end

  // Remember the window so a change can be detected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wl_reg <= '0;
    else       wl_reg <= wl_clamped;
  end

  // Stage-1 pipeline register: capture sample, channel and oldest sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_ch     <= '0;
      s1_data   <= '0;
      s1_oldest <= '0;
      s1_drop   <= 1'b0;
      s1_full   <= 1'b0;
      s1_wl     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ch     <= channel;
        s1_data   <= input_data;
        s1_oldest <= sample_mem[channel][rd_idx];
        s1_drop   <= (count_before >= win_size);
        s1_full   <= (count_after >= win_size);
        s1_wl     <= wl_clamped;
      end
    end
  end

  // Sample RAM write; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) sample_mem[channel][wr_idx] <= input_data;
  end

  // Per-channel pointers, counts and sums, with global clear on flush or window change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wr_ptr[i]  <= '0;
        count[i]   <= '0;
        sum_mem[i] <= '0;
      end
    end else begin
      if (clear_all) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          wr_ptr[i]  <= '0;
          count[i]   <= '0;
          sum_mem[i] <= '0;
        end
      end else if (s1_valid) begin
        sum_mem[s1_ch] <= sum_next;
      end
      if (accept) begin
        wr_ptr[channel] <= wr_idx + 1'b1;
        count[channel]  <= count_after;
      end
    end
  end

  // Output registers: strobe valid for one cycle, hold data otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_data        <= '0;
      output_mean        <= '0;
      output_channel     <= '0;
      output_data_valid  <= 1'b0;
      output_window_full <= 1'b0;
    end else begin
      output_data_valid <= s1_valid;
      if (s1_valid) begin
        output_data        <= sum_next;
        output_mean        <= mean_full[DATA_SIZE-1:0];
        output_channel     <= s1_ch;
        output_window_full <= s1_full;
      end
    end
  end

endmodule

// File: tb/tb_multichannel_moving_average.sv
// Directed testbench for multichannel_moving_average: each sample carries
// its hand-computed result, which must appear exactly two cycles later.
module tb_multichannel_moving_average;

  localparam int DATA_SIZE = 16;
  localparam int FULL_SIZE = 22;

  logic                        clk;
  logic                        reset;
  logic signed [DATA_SIZE-1:0] input_data;
  logic                        enable;
  logic [1:0]                  channel;
  logic [2:0]                  window_log2;
  logic                        flush;
  logic signed [FULL_SIZE-1:0] output_data;
  logic signed [DATA_SIZE-1:0] output_mean;
  logic [1:0]                  output_channel;
  logic                        output_data_valid;
  logic                        output_window_full;

  typedef struct {
    int     due;
    int     ch;
    longint sum;
    longint mean;
    int     full;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  multichannel_moving_average dut (
    .clk                (clk),
    .reset              (reset),
    .input_data         (input_data),
    .enable             (enable),
    .channel            (channel),
    .window_log2        (window_log2),
    .flush              (flush),
    .output_data        (output_data),
    .output_mean        (output_mean),
    .output_channel     (output_channel),
    .output_data_valid  (output_data_valid),
    .output_window_full (output_window_full)
  );

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: count it, report any mismatch.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs; when has_res is set queue the result due two cycles later.
  task automatic applyStimulus(input int ch, input int data, input int wl, input bit fl,
                               input bit has_res, input longint e_sum, input longint e_mean,
                               input int e_full);
    exp_t e;
    @(negedge clk);
    enable      = 1'b1;
    channel     = 2'(ch);
    input_data  = 16'(data);
    window_log2 = 3'(wl);
    flush       = fl;
    if (has_res) begin
      e.due  = cyc + 2;
      e.ch   = ch;
      e.sum  = e_sum;
      e.mean = e_mean;
      e.full = e_full;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b0;
      flush  = 1'b0;
    end
  endtask

  // Monitor: a result must be present exactly when one is due, and only then.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        checkOutput("valid", longint'(output_data_valid), 1);
        checkOutput("channel", longint'(output_channel), longint'(exp_q[0].ch));
        checkOutput("sum", longint'(output_data), exp_q[0].sum);
        checkOutput("mean", longint'(output_mean), exp_q[0].mean);
        checkOutput("full", longint'(output_window_full), longint'(exp_q[0].full));
        void'(exp_q.pop_front());
      end else begin
        checkOutput("idle_valid", longint'(output_data_valid), 0);
      end
    end
  end

  initial begin
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    enable      = 1'b0;
    flush       = 1'b0;
    channel     = '0;
    input_data  = '0;
    window_log2 = 3'd2;

    repeat (3) @(negedge clk);
    checkOutput("rst_data", longint'(output_data), 0);
    checkOutput("rst_mean", longint'(output_mean), 0);
    checkOutput("rst_valid", longint'(output_data_valid), 0);
    checkOutput("rst_full", longint'(output_window_full), 0);
    checkOutput("rst_channel", longint'(output_channel), 0);
    reset = 1'b0;
    idle(2);

    $display("[TB] test 1: window 4, ch0 ramp");
    applyStimulus(0, 1, 2, 0, 1, 1, 0, 0);
    applyStimulus(0, 2, 2, 0, 1, 3, 0, 0);
    applyStimulus(0, 3, 2, 0, 1, 6, 1, 0);
    applyStimulus(0, 4, 2, 0, 1, 10, 2, 1);
    applyStimulus(0, 5, 2, 0, 1, 14, 3, 1);
    idle(4);

    $display("[TB] test 2: window 2, interleaved ch0/ch1");
    applyStimulus(0, 100, 1, 0, 1, 100, 50, 0);
    applyStimulus(1, -100, 1, 0, 1, -100, -50, 0);
    applyStimulus(0, 100, 1, 0, 1, 200, 100, 1);
    applyStimulus(1, -100, 1, 0, 1, -200, -100, 1);
    applyStimulus(0, 100, 1, 0, 1, 200, 100, 1);
    applyStimulus(1, -100, 1, 0, 1, -200, -100, 1);
    idle(4);

    $display("[TB] test 3: window 64, full-scale fill on ch3");
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(3, 32767, 6, 0, 1, longint'(i) * 32767, (longint'(i) * 32767) / 64,
                    (i == 64) ? 1 : 0);
    end
    applyStimulus(3, -32768, 6, 0, 1, 2031553, 31743, 1);
    idle(3);
    // window_log2 above the maximum clamps to 64, so no clear happens
    applyStimulus(3, 0, 7, 0, 1, 1998786, 31231, 1);
    idle(4);

    $display("[TB] test 4: window change 4 -> 1 mid-stream");
    applyStimulus(0, 5, 2, 0, 1, 5, 1, 0);
    applyStimulus(0, 5, 2, 0, 1, 10, 2, 0);
    applyStimulus(0, 7, 0, 0, 1, 7, 7, 1);
    idle(4);

    $display("[TB] test 5: flush with enable on ch2");
    applyStimulus(2, 4, 2, 0, 1, 4, 1, 0);
    applyStimulus(2, 8, 2, 0, 1, 12, 3, 0);
    applyStimulus(2, 50, 2, 1, 0, 0, 0, 0);
    idle(2);
    applyStimulus(2, 9, 2, 0, 1, 9, 2, 0);
    idle(4);

    $display("[TB] test 6: negative mean floors");
    applyStimulus(1, -3, 1, 0, 1, -3, -2, 0);
    applyStimulus(1, -2, 1, 0, 1, -5, -3, 1);
    idle(5);

    checkOutput("drain", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
